me_search_ctrl_param: RTL and testbench

Parametrised integer-pel search controller for the motion estimation datapath. It accepts a search request over a four-phase req/ack handshake and sequences the search-window and template-block address generators. It also drives delayed SAD-array enables and tracks the running minimum SAD across a streamed set of candidate results. It generalises the fixed 3x3 / 16x16 controller to any candidate grid and block size, and adds abort, drain timeout and an error flag.

---
 rtl/me_search_ctrl_param.sv | 193 +++++++++++++++++++
 tb/tb_me_search_ctrl_param.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_search_ctrl_param.sv
// Integer-pel motion-estimation search controller: sequences SW/TB address
// generators, delays SAD-array enables and tracks the minimum candidate SAD.
module me_search_ctrl_param #(
    parameter int TB_LEN   = 16,
    parameter int CAND_DIM = 3,
    parameter int SAD_W    = 16,
    parameter int POS_W    = 12,
    parameter int ARR_DLY  = 2,
    parameter int DIFF_W   = 2*$clog2(CAND_DIM),
    parameter int DRAIN_TO = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   req,
    input  logic                                   abort,
    input  logic [POS_W-1:0]                       init_pos,
    input  logic                                   sad_valid,
    input  logic [SAD_W-1:0]                       sad,
    input  logic [DIFF_W-1:0]                      vec_diff,
    output logic                                   clr,
    output logic                                   en_addr_sw,
    output logic                                   en_addr_tb,
    output logic                                   en_sadarray_sw,
    output logic                                   en_sadarray_tb,
    output logic [POS_W-1:0]                       init_mvec,
    output logic [SAD_W-1:0]                       min_sad,
    output logic [DIFF_W-1:0]                      min_diff,
    output logic [$clog2(CAND_DIM*CAND_DIM+1)-1:0] cand_cnt,
    output logic                                   busy,
    output logic                                   err,
    output logic                                   ack
);

    localparam int SW_LEN = TB_LEN + CAND_DIM - 1;
    localparam int NCAND  = CAND_DIM * CAND_DIM;
    localparam int CNT_W  = $clog2(NCAND + 1);
    localparam int HW     = (SW_LEN > 1) ? $clog2(SW_LEN) : 1;
    localparam int TW     = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;

    localparam logic [HW-1:0]    H_LAST  = HW'(SW_LEN - 1);
    localparam logic [HW-1:0]    CD_M1   = HW'(CAND_DIM - 1);
    localparam logic [TW-1:0]    T_LAST  = TW'(DRAIN_TO - 1);
    localparam logic [CNT_W-1:0] NCAND_C = CNT_W'(NCAND);

    typedef enum logic [2:0] {IDLE, CLR, SCAN, DRAIN, RESULT} state_t;

    state_t             state;
    logic [HW-1:0]      cnt_h, cnt_w;
    logic [TW-1:0]      timer;
    logic [ARR_DLY-1:0] sw_dly, tb_dly;
    logic [SAD_W-1:0]   base_sad;
    logic [DIFF_W-1:0]  base_diff;
    logic [CNT_W-1:0]   base_cnt;
    logic               track;

    assign en_addr_sw     = (state == SCAN);
    assign en_sadarray_sw = sw_dly[ARR_DLY-1];
    assign en_sadarray_tb = tb_dly[ARR_DLY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr        <= 1'b0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            en_addr_tb <= 1'b0;
            cnt_h      <= '0;
            cnt_w      <= '0;
            timer      <= '0;
        end else if (abort) begin
            state      <= IDLE;
            clr        <= 1'b0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            en_addr_tb <= 1'b0;
        end else begin
            clr        <= 1'b0;
            en_addr_tb <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= CLR;
                        clr   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                CLR: begin
                    state <= SCAN;
                    cnt_h <= '0;
                    cnt_w <= '0;
                    err   <= 1'b0;
                end
                SCAN: begin
                    // TB window sits in the lower-right TB_LEN x TB_LEN of the scan
                    en_addr_tb <= (cnt_h >= CD_M1) && (cnt_w >= CD_M1);
                    if (cnt_h == H_LAST) begin
                        cnt_h <= '0;
                        if (cnt_w == H_LAST) begin
                            state <= DRAIN;
                            timer <= '0;
                        end else begin
                            cnt_w <= cnt_w + 1'b1;
                        end
                    end else begin
                        cnt_h <= cnt_h + 1'b1;
                    end
                end
                DRAIN: begin
                    timer <= timer + 1'b1;
                    if (cand_cnt == NCAND_C) begin
                        state <= RESULT;
                        busy  <= 1'b0;
                        ack   <= 1'b1;
                    end else if (timer == T_LAST) begin
                        state <= RESULT;
                        busy  <= 1'b0;
                        ack   <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                RESULT: begin
                    if (!req) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

    // Enable delay lines keep shifting in IDLE so trailing enables drain out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_dly <= '0;
            tb_dly <= '0;
        end else if (abort) begin
            sw_dly <= '0;
            tb_dly <= '0;
        end else begin
            sw_dly[0] <= en_addr_sw;
            tb_dly[0] <= en_addr_tb;
            for (int i = 1; i < ARR_DLY; i++) begin
                sw_dly[i] <= sw_dly[i-1];
                tb_dly[i] <= tb_dly[i-1];
            end
        end
    end

    // A strobe in CLR compares against the freshly cleared values.
    always_comb begin
        base_sad  = min_sad;
        base_diff = min_diff;
        base_cnt  = cand_cnt;
        if (state == CLR) begin
            base_sad  = '1;
            base_diff = '0;
            base_cnt  = '0;
        end
    end

    assign track = (state == CLR) || (state == SCAN) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_mvec <= '0;
            min_sad   <= '1;
            min_diff  <= '0;
            cand_cnt  <= '0;
        end else if (!abort) begin
            if (state == CLR) init_mvec <= init_pos;
            if (track) begin
                min_sad  <= base_sad;
                min_diff <= base_diff;
                cand_cnt <= base_cnt;
                if (sad_valid) begin
                    if (base_cnt != NCAND_C) cand_cnt <= base_cnt + 1'b1;
                    // first candidate always lands so min_diff names a real one
                    if (sad < base_sad || base_cnt == '0) begin
                        min_sad  <= sad;
                        min_diff <= vec_diff;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_me_search_ctrl_param.sv
// Bench for me_search_ctrl_param: vector table, randomized searches against a
// reference model, abort/reset corner cases and a 5x5 / 8x8 instance.
module tb_me_search_ctrl_param;

    localparam int TBL = 16, CD = 3, SW = TBL + CD - 1, NC = CD * CD, ARR = 2, DTO = 64;
    localparam int TBL5 = 8, CD5 = 5, SW5 = TBL5 + CD5 - 1, NC5 = CD5 * CD5;

    logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, abort = 1'b0, sad_valid = 1'b0;
    logic [11:0] init_pos = '0;
    logic [15:0] sad = '0;
    logic [3:0]  vec_diff = '0;
    logic clr, en_addr_sw, en_addr_tb, en_sadarray_sw, en_sadarray_tb, busy, err, ack;
    logic [11:0] init_mvec;
    logic [15:0] min_sad;
    logic [3:0]  min_diff;
    logic [3:0]  cand_cnt;

    logic req5 = 1'b0, abort5 = 1'b0, sad_valid5 = 1'b0;
    logic [11:0] init_pos5 = '0;
    logic [15:0] sad5 = '0;
    logic [5:0]  vec_diff5 = '0;
    logic clr5, en_addr_sw5, en_addr_tb5, en_sadarray_sw5, en_sadarray_tb5, busy5, err5, ack5;
    logic [11:0] init_mvec5;
    logic [15:0] min_sad5;
    logic [5:0]  min_diff5;
    logic [4:0]  cand_cnt5;

    me_search_ctrl_param dut (
        .clk(clk), .rst_n(rst_n), .req(req), .abort(abort), .init_pos(init_pos),
        .sad_valid(sad_valid), .sad(sad), .vec_diff(vec_diff), .clr(clr),
        .en_addr_sw(en_addr_sw), .en_addr_tb(en_addr_tb), .en_sadarray_sw(en_sadarray_sw),
        .en_sadarray_tb(en_sadarray_tb), .init_mvec(init_mvec), .min_sad(min_sad),
        .min_diff(min_diff), .cand_cnt(cand_cnt), .busy(busy), .err(err), .ack(ack)
    );

    me_search_ctrl_param #(.TB_LEN(TBL5), .CAND_DIM(CD5)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .abort(abort5), .init_pos(init_pos5),
        .sad_valid(sad_valid5), .sad(sad5), .vec_diff(vec_diff5), .clr(clr5),
        .en_addr_sw(en_addr_sw5), .en_addr_tb(en_addr_tb5), .en_sadarray_sw(en_sadarray_sw5),
        .en_sadarray_tb(en_sadarray_tb5), .init_mvec(init_mvec5), .min_sad(min_sad5),
        .min_diff(min_diff5), .cand_cnt(cand_cnt5), .busy(busy5), .err(err5), .ack(ack5)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        int          last_at;
        logic [15:0] s[9];
        logic [15:0] e_min;
        int          e_diff;
        int          e_cnt;
        logic        e_err;
    } vec_t;

    vec_t        tv[8];
    int          tests = 0, fails = 0, dly_bad = 0;
    logic [ARR-1:0] m_sw = '0, m_tb = '0;
    logic        e_sw_prev = 1'b0, e_tb_prev = 1'b0;
    logic [15:0] cand_sad[25];
    int          del_t[25];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One cycle; tracks the expected delayed enables of the default instance.
    task automatic tick();
        @(negedge clk);
        if (abort || !rst_n) begin
            m_sw = '0;
            m_tb = '0;
        end else begin
            m_sw = {m_sw[ARR-2:0], e_sw_prev};
            m_tb = {m_tb[ARR-2:0], e_tb_prev};
        end
        if (en_sadarray_sw !== m_sw[ARR-1] || en_sadarray_tb !== m_tb[ARR-1]) dly_bad++;
        e_sw_prev = en_addr_sw;
        e_tb_prev = en_addr_tb;
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_clr"}, clr, 0);
        chk({t, "_en_sw"}, en_addr_sw, 0);
        chk({t, "_en_tb"}, en_addr_tb, 0);
        chk({t, "_arr_sw"}, en_sadarray_sw, 0);
        chk({t, "_arr_tb"}, en_sadarray_tb, 0);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_err"}, err, 0);
        chk({t, "_ack"}, ack, 0);
        chk({t, "_cand_cnt"}, cand_cnt, 0);
        chk({t, "_min_sad"}, min_sad, 16'hffff);
        chk({t, "_min_diff"}, min_diff, 0);
        chk({t, "_init_mvec"}, init_mvec, 0);
    endtask

    // Minimum of the delivered SADs; first candidate holding it wins.
    task automatic ref_model(input int n, output logic [15:0] m, output int d);
        m = 16'hffff;
        d = 0;
        for (int i = 0; i < n; i++) if (cand_sad[i] < m) m = cand_sad[i];
        for (int i = n - 1; i >= 0; i--) if (cand_sad[i] == m) d = i;
    endtask

    task automatic run_dflt(input int n, input int abort_at, input logic [15:0] e_min,
                            input int e_diff, input int e_cnt, input logic e_err, input string nm);
        int clr_cyc, sw_cnt, tb_cnt, tb_first, ack_cyc, k, last_c, ab_stage, c, d_cyc, exp_ack;
        logic [11:0] ip;
        ip = 12'($urandom);
        init_pos = ip;
        req = 1'b1;
        clr_cyc = -1; ack_cyc = -1; k = 0; last_c = 0; ab_stage = 0;
        sw_cnt = 0; tb_cnt = 0; tb_first = -1; c = 0;
        while (ack_cyc < 0 && c < 3000) begin
            tick();
            c++;
            if (ab_stage == 1) begin
                chk({nm, "_abort_busy"}, busy, 0);
                chk({nm, "_abort_en_sw"}, en_addr_sw, 0);
                chk({nm, "_abort_en_tb"}, en_addr_tb, 0);
                abort = 1'b0;
                ab_stage = 2;
            end else if (ab_stage == 2) begin
                chk({nm, "_restart_clr"}, clr, 1);
                ab_stage = 3;
            end
            if (clr) begin
                clr_cyc = c; k = 0; sw_cnt = 0; tb_cnt = 0; tb_first = -1;
            end
            if (en_addr_sw) sw_cnt++;
            if (en_addr_tb) begin
                if (tb_first < 0) tb_first = c - clr_cyc;
                tb_cnt++;
            end
            if (ack) begin
                ack_cyc = c;
            end else begin
                sad_valid = 1'b0;
                sad = 16'($urandom);
                vec_diff = 4'($urandom);
                if (clr_cyc >= 0 && k < n && c - clr_cyc == del_t[k]) begin
                    sad_valid = 1'b1;
                    sad = cand_sad[k];
                    vec_diff = 4'(k);
                    k++;
                    last_c = c;
                end
                if (abort_at >= 0 && ab_stage == 0 && clr_cyc >= 0 && c == clr_cyc + 1 + abort_at) begin
                    abort = 1'b1;
                    ab_stage = 1;
                end
            end
        end
        sad_valid = 1'b0;
        chk({nm, "_ack"}, ack, 1);
        chk({nm, "_sw_cycles"}, sw_cnt, SW * SW);
        chk({nm, "_tb_cycles"}, tb_cnt, TBL * TBL);
        chk({nm, "_tb_first"}, tb_first, (CD - 1) * SW + CD + 1);
        d_cyc = clr_cyc + 1 + SW * SW;
        exp_ack = d_cyc + DTO;
        if (n >= NC) begin
            exp_ack = ((last_c + 1 > d_cyc) ? last_c + 1 : d_cyc) + 1;
            if (exp_ack > d_cyc + DTO) exp_ack = d_cyc + DTO;
        end
        chk({nm, "_ack_cycle"}, ack_cyc, exp_ack);
        chk({nm, "_min_sad"}, min_sad, e_min);
        chk({nm, "_min_diff"}, min_diff, e_diff);
        chk({nm, "_cand_cnt"}, cand_cnt, e_cnt);
        chk({nm, "_err"}, err, e_err);
        chk({nm, "_init_mvec"}, init_mvec, ip);
        chk({nm, "_busy_result"}, busy, 0);
        for (int i = 0; i < 3; i++) begin
            sad_valid = 1'b1; sad = 16'd0; vec_diff = 4'(i);
            tick();
        end
        chk({nm, "_ack_hold"}, ack, 1);
        chk({nm, "_hold_min"}, min_sad, e_min);
        chk({nm, "_hold_cnt"}, cand_cnt, e_cnt);
        req = 1'b0;
        tick();
        sad_valid = 1'b0;
        chk({nm, "_ack_drop"}, ack, 0);
        chk({nm, "_idle_min"}, min_sad, e_min);
        repeat (3) tick();
        chk({nm, "_sadarray_delay"}, dly_bad, 0);
        dly_bad = 0;
    endtask

    task automatic load_vec(input int i);
        for (int j = 0; j < 9; j++) begin
            cand_sad[j] = tv[i].s[j];
            del_t[j] = 5 + 7 * j;
        end
        if (tv[i].last_at > 0) del_t[tv[i].n - 1] = tv[i].last_at;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] em;
        int ed, n, c, clr_c, sw5, tb5, k;

        tv[0] = '{n: 9, last_at: 0, s: '{500, 300, 300, 900, 120, 120, 700, 800, 999},
                  e_min: 16'd120, e_diff: 4, e_cnt: 9, e_err: 1'b0};
        tv[1] = '{n: 5, last_at: 0, s: '{50, 40, 40, 60, 70, 0, 0, 0, 0},
                  e_min: 16'd40, e_diff: 1, e_cnt: 5, e_err: 1'b1};
        tv[2] = '{n: 9, last_at: 0, s: '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000},
                  e_min: 16'd1000, e_diff: 0, e_cnt: 9, e_err: 1'b0};
        tv[3] = '{n: 9, last_at: 0, s: '{900, 800, 700, 600, 500, 400, 300, 200, 100},
                  e_min: 16'd100, e_diff: 8, e_cnt: 9, e_err: 1'b0};
        tv[4] = '{n: 9, last_at: 0, s: '{16'hffff, 16'hffff, 16'hffff, 16'hffff, 16'hffff,
                                          16'hffff, 16'hffff, 16'hffff, 16'hffff},
                  e_min: 16'hffff, e_diff: 0, e_cnt: 9, e_err: 1'b0};
        tv[5] = '{n: 9, last_at: 0, s: '{16'hffff, 16'hffff, 16'hffff, 10, 20, 10, 30, 40, 50},
                  e_min: 16'd10, e_diff: 3, e_cnt: 9, e_err: 1'b0};
        // last candidate lands in the timeout cycle: counted, compared, err set
        tv[6] = '{n: 9, last_at: 1 + SW * SW + DTO - 1,
                  s: '{900, 800, 700, 600, 500, 400, 300, 200, 50},
                  e_min: 16'd50, e_diff: 8, e_cnt: 9, e_err: 1'b1};
        tv[7] = '{n: 0, last_at: 0, s: '{0, 0, 0, 0, 0, 0, 0, 0, 0},
                  e_min: 16'hffff, e_diff: 0, e_cnt: 0, e_err: 1'b1};

        repeat (3) tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            load_vec(i);
            run_dflt(tv[i].n, -1, tv[i].e_min, tv[i].e_diff, tv[i].e_cnt, tv[i].e_err,
                     $sformatf("vec%0d", i));
        end

        load_vec(0);
        run_dflt(9, 100, tv[0].e_min, tv[0].e_diff, 9, 1'b0, "abort");

        for (int r = 0; r < 8; r++) begin
            n = (r % 3 == 2) ? int'($urandom_range(0, NC - 1)) : NC;
            for (int j = 0; j < NC; j++) begin
                cand_sad[j] = ($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom_range(0, 20));
                del_t[j] = ((j == 0) ? 0 : del_t[j-1]) + int'($urandom_range(1, 40));
            end
            ref_model(n, em, ed);
            run_dflt(n, -1, em, ed, n, (n < NC) || (n > 0 && del_t[n-1] >= SW * SW + DTO),
                     $sformatf("rnd%0d", r));
        end

        // asynchronous reset while draining
        init_pos = 12'h3c3;
        req = 1'b1;
        c = 0;
        while (!clr && c < 20) begin tick(); c++; end
        chk("rst_drain_clr_seen", clr, 1);
        sad_valid = 1'b1; sad = 16'd7; vec_diff = 4'd2;
        tick();
        sad_valid = 1'b0;
        repeat (SW * SW + 10) tick();
        chk("rst_drain_busy", busy, 1);
        chk("rst_drain_min_before", min_sad, 7);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_drain");
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        dly_bad = 0;
        load_vec(0);
        run_dflt(9, -1, tv[0].e_min, tv[0].e_diff, 9, 1'b0, "after_rst");

        // 5x5 candidates, 8x8 block
        for (int j = 0; j < NC5; j++) cand_sad[j] = 16'(1000 + $urandom_range(0, 5000));
        cand_sad[17] = 16'd77;
        cand_sad[22] = 16'd77;
        init_pos5 = 12'h5a5;
        req5 = 1'b1;
        clr_c = -1; sw5 = 0; tb5 = 0; k = 0; c = 0;
        while (!ack5 && c < 1000) begin
            tick();
            c++;
            if (clr5) clr_c = c;
            if (en_addr_sw5) sw5++;
            if (en_addr_tb5) tb5++;
            sad_valid5 = 1'b0;
            if (clr_c >= 0 && k < NC5 && c - clr_c == 2 + 2 * k) begin
                sad_valid5 = 1'b1;
                sad5 = cand_sad[k];
                vec_diff5 = 6'(k);
                k++;
            end
        end
        sad_valid5 = 1'b0;
        chk("cd5_ack", ack5, 1);
        chk("cd5_sw_cycles", sw5, SW5 * SW5);
        chk("cd5_tb_cycles", tb5, TBL5 * TBL5);
        chk("cd5_min_sad", min_sad5, 77);
        chk("cd5_min_diff", min_diff5, 17);
        chk("cd5_cand_cnt", cand_cnt5, NC5);
        chk("cd5_err", err5, 0);
        chk("cd5_init_mvec", init_mvec5, 12'h5a5);
        req5 = 1'b0;
        tick();
        chk("cd5_ack_drop", ack5, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
